// File: rtl/division.sv
// rtl/division.sv - Multi-cycle unsigned 32-bit restoring divider, one quotient bit per clock.
module division (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q,
  output logic [31:0] r,
  output logic        done
);

  typedef enum logic {
    st_idle = 1'b0,
    st_busy = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [5:0]  count;
  logic [31:0] divisor;
  logic [31:0] rem;
  // Dividend bits shift out of the top while quotient bits shift in at the
  // bottom, so after 32 steps this register holds the quotient.
  logic [31:0] dq;

  logic [32:0] p;
  logic        fits;
  logic [31:0] diff;
  logic [31:0] rem_step;
  logic [31:0] dq_step;
  logic        last;

  always_comb begin
    p        = {rem, dq[31]};
    fits     = (p >= {1'b0, divisor});
    // p < 2*divisor whenever fits, so the 32-bit difference is exact.
    diff     = p[31:0] - divisor;
    rem_step = fits ? diff : p[31:0];
    dq_step  = {dq[30:0], fits};
    last     = (count == 6'd31);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= st_idle;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      st_idle: if (start) state_next = st_busy;
      st_busy: if (last)  state_next = st_idle;
      default: state_next = st_idle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count   <= 6'd0;
      divisor <= 32'd0;
      rem     <= 32'd0;
      dq      <= 32'd0;
      q       <= 32'd0;
      r       <= 32'd0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        st_idle: begin
          if (start) begin
            dq      <= a;
            divisor <= b;
            rem     <= 32'd0;
            count   <= 6'd0;
          end
        end
        st_busy: begin
          dq    <= dq_step;
          rem   <= rem_step;
          count <= count + 6'd1;
          if (last) begin
            q     <= dq_step;
            r     <= rem_step;
            done  <= 1'b1;
            count <= 6'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_division.sv
// tb/tb_division.sv - Scoreboard bench for the multi-cycle divider.
module tb_division;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] q;
  logic [31:0] r;
  logic        done;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_r[$];
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];

  division dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .a(a),
    .b(b),
    .q(q),
    .r(r),
    .done(done)
  );

  always #2 clock = ~clock;

  // Called 1 time unit after a rising edge; consumes the start edge.
  task automatic launch(input logic [31:0] aa, input logic [31:0] bb, input bit track);
    a = aa;
    b = bb;
    start = 1'b1;
    if (track) begin
      exp_a.push_back(aa);
      exp_b.push_back(bb);
      if (bb == 32'd0) begin
        exp_q.push_back(32'hFFFF_FFFF);
        exp_r.push_back(aa);
      end else begin
        exp_q.push_back(aa / bb);
        exp_r.push_back(aa % bb);
      end
    end
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clock);
      #1;
      if (done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    a = 32'd0;
    b = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    checks++;
    if (q !== 32'd0 || r !== 32'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got q=%h r=%h done=%b want 0 0 0", q, r, done);
    end
  endtask

  task automatic test_basic;
    logic [31:0] eq, er, ea, eb;
    int cyc;
    logic [31:0] held;
    logic [31:0] ops_a[3];
    logic [31:0] ops_b[3];
    ops_a[0] = 32'd14;         ops_b[0] = 32'd3;
    ops_a[1] = 32'hFFFF_FFFF;  ops_b[1] = 32'd1;
    ops_a[2] = 32'd5;          ops_b[2] = 32'd9;
    for (int k = 0; k < 3; k++) begin
      held = q;
      launch(ops_a[k], ops_b[k], 1'b1);
      a = 32'hDEAD_BEEF;
      b = 32'h0000_0003;
      checks++;
      if (q !== held) begin
        failures++;
        $display("FAIL basic_hold_q[%0d] got=%h want=%h", k, q, held);
      end
      wait_done(40, cyc);
      checks++;
      if (cyc !== 32) begin
        failures++;
        $display("FAIL basic_latency[%0d] got=%0d want=32", k, cyc);
      end
      if (exp_q.size() > 0) begin
        eq = exp_q.pop_front();
        er = exp_r.pop_front();
        ea = exp_a.pop_front();
        eb = exp_b.pop_front();
        checks++;
        if (q !== eq || r !== er) begin
          failures++;
          $display("FAIL basic_result[%0d] %0d/%0d got q=%h r=%h want q=%h r=%h", k, ea, eb, q, r, eq, er);
        end
      end
      @(posedge clock);
      #1;
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("FAIL basic_done_width[%0d] got=%b want=0", k, done);
      end
    end
  endtask

  task automatic test_div_zero;
    int cyc;
    logic [31:0] eq, er;
    launch(32'd7, 32'd0, 1'b1);
    wait_done(40, cyc);
    void'(exp_a.pop_front());
    void'(exp_b.pop_front());
    eq = exp_q.pop_front();
    er = exp_r.pop_front();
    checks++;
    if (cyc !== 32 || q !== eq || r !== er) begin
      failures++;
      $display("FAIL div_zero got cyc=%0d q=%h r=%h want cyc=32 q=%h r=%h", cyc, q, r, eq, er);
    end
  endtask

  task automatic test_ignore_start;
    int cyc;
    logic [31:0] eq, er;
    launch(32'd100, 32'd7, 1'b1);
    repeat (9) @(posedge clock);
    #1;
    launch(32'd1, 32'd1, 1'b0);
    wait_done(40, cyc);
    void'(exp_a.pop_front());
    void'(exp_b.pop_front());
    eq = exp_q.pop_front();
    er = exp_r.pop_front();
    checks++;
    if (cyc !== 22) begin
      failures++;
      $display("FAIL ignore_start_latency got=%0d want=22", cyc);
    end
    checks++;
    if (q !== eq || r !== er) begin
      failures++;
      $display("FAIL ignore_start_result got q=%0d r=%0d want q=%0d r=%0d", q, r, eq, er);
    end
  endtask

  task automatic test_reset_abort;
    int cyc;
    logic [31:0] eq, er;
    launch(32'd1000, 32'd10, 1'b1);
    repeat (14) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.delete();
    exp_r.delete();
    exp_a.delete();
    exp_b.delete();
    checks++;
    if (q !== 32'd0 || r !== 32'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_state got q=%h r=%h done=%b want 0 0 0", q, r, done);
    end
    wait_done(40, cyc);
    checks++;
    if (cyc !== -1) begin
      failures++;
      $display("FAIL abort_no_done got done at cycle %0d want none", cyc);
    end
    launch(32'd1000, 32'd10, 1'b1);
    wait_done(40, cyc);
    void'(exp_a.pop_front());
    void'(exp_b.pop_front());
    eq = exp_q.pop_front();
    er = exp_r.pop_front();
    checks++;
    if (cyc !== 32 || q !== eq || r !== er) begin
      failures++;
      $display("FAIL abort_restart got cyc=%0d q=%0d r=%0d want cyc=32 q=%0d r=%0d", cyc, q, r, eq, er);
    end
  endtask

  task automatic test_reset_start;
    int cyc;
    reset = 1'b1;
    start = 1'b1;
    a = 32'd77;
    b = 32'd5;
    @(posedge clock);
    #1;
    reset = 1'b0;
    start = 1'b0;
    checks++;
    if (q !== 32'd0 || r !== 32'd0) begin
      failures++;
      $display("FAIL reset_start_clear got q=%h r=%h want 0 0", q, r);
    end
    wait_done(40, cyc);
    checks++;
    if (cyc !== -1) begin
      failures++;
      $display("FAIL reset_start_idle got done at cycle %0d want none", cyc);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    logic [31:0] eq, er, ea, eb;
    logic [31:0] na, nb;
    logic [63:0] recon;
    int n = 10;
    launch($urandom, $urandom_range(1, 255), 1'b1);
    for (int k = 0; k < n; k++) begin
      wait_done(40, cyc);
      checks++;
      if (cyc !== 32) begin
        failures++;
        $display("FAIL b2b_latency[%0d] got=%0d want=32", k, cyc);
      end
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b2b_scoreboard[%0d] got empty queue want entry", k);
        break;
      end
      eq = exp_q.pop_front();
      er = exp_r.pop_front();
      ea = exp_a.pop_front();
      eb = exp_b.pop_front();
      checks++;
      if (q !== eq || r !== er) begin
        failures++;
        $display("FAIL b2b_result[%0d] %h/%h got q=%h r=%h want q=%h r=%h", k, ea, eb, q, r, eq, er);
      end
      if (eb != 32'd0) begin
        recon = 64'(q) * 64'(eb) + 64'(r);
        checks++;
        if (recon !== 64'(ea) || !(r < eb)) begin
          failures++;
          $display("FAIL b2b_identity[%0d] got q*b+r=%h r=%h want a=%h r<b=%h", k, recon, r, ea, eb);
        end
      end
      if (k < n - 1) begin
        na = $urandom;
        if (k == 3)          nb = 32'd0;
        else if (k % 3 == 0) nb = $urandom_range(1, 255);
        else if (k % 3 == 1) nb = $urandom;
        else                 nb = na >> $urandom_range(0, 8);
        launch(na, nb, 1'b1);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    a = 32'd0;
    b = 32'd0;
    test_reset();
    test_basic();
    test_div_zero();
    test_ignore_start();
    test_reset_abort();
    test_reset_start();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
